// File: rtl/dotp_pkg.sv
// Shared types and derived constants for the dot-product run sequencer.
package dotp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DONE    = 3'd4
    } dotp_seq_state_t;

    localparam int unsigned DEF_DATA_BITS   = 4;
    localparam int unsigned DEF_PIPE_STAGES = 4;
    localparam int unsigned Nums_Data       = 1 << DEF_DATA_BITS;
    localparam int unsigned Compute_Cycles  = Nums_Data + DEF_PIPE_STAGES;

    // One extra bit over log2(vector length) reaches 2*Nums_Data-1.
    function automatic int unsigned phase_count_width(input int unsigned data_bits);
        return data_bits + 1;
    endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// In-phase cycle counter: clears, counts when enabled, flags the limit value.
module seq_phase_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = en && (count_q == limit);

endmodule

// File: rtl/dotp_sequencer.sv
// Run controller: CLEAR -> LOAD -> COMPUTE -> DONE on each start pulse.
// Optional run counter enabled by defining DOTP_SEQ_RUN_COUNT_EN.
module dotp_sequencer
    import dotp_pkg::*;
#(
    parameter int unsigned Nums_Data_in_bits    = 4,
    parameter int unsigned Nums_Pipeline_Stages = 4,
    parameter int unsigned Compute_Cycles       = (1 << Nums_Data_in_bits) + Nums_Pipeline_Stages
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       Mem_reset,
    output logic                       Comp_reset,
    output logic                       Mem_Index_reset,
    output logic                       load_from_file,
    output logic                       Computing,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [2:0]                 state,
    output logic [Nums_Data_in_bits:0] phase_count
`ifdef DOTP_SEQ_RUN_COUNT_EN
    ,
    output logic [15:0]                run_count
`endif
);

    localparam int unsigned    PCW       = phase_count_width(Nums_Data_in_bits);
    localparam int unsigned    LOAD_LEN  = 1 << Nums_Data_in_bits;
    localparam logic [PCW-1:0] LOAD_LAST = PCW'(LOAD_LEN - 1);
    localparam logic [PCW-1:0] COMP_LAST = PCW'(Compute_Cycles - 1);

    dotp_seq_state_t state_q;
    dotp_seq_state_t state_d;
    logic            aborted_q;
    logic            aborted_d;
    logic            cnt_clear_s;
    logic            cnt_en_s;
    logic [PCW-1:0]  cnt_limit_s;
    logic [PCW-1:0]  cnt_value_s;
    logic            cnt_terminal_s;

    seq_phase_counter #(
        .W (PCW)
    ) u_phase_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear_s),
        .en       (cnt_en_s),
        .limit    (cnt_limit_s),
        .count    (cnt_value_s),
        .terminal (cnt_terminal_s)
    );

    // Next-state logic; abort is honoured in every active state except DONE.
    always_comb begin
        state_d     = state_q;
        aborted_d   = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_limit_s = LOAD_LAST;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_en_s = 1'b1;
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_terminal_s) begin
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                cnt_en_s    = 1'b1;
                cnt_limit_s = COMP_LAST;
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_terminal_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cnt_clear_s = (state_d != state_q) || !cnt_en_s;
    end

    // State and abort-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= aborted_d;
        end
    end

    assign Mem_reset       = (state_q == ST_CLEAR);
    assign Comp_reset      = (state_q == ST_CLEAR);
    assign Mem_Index_reset = (state_q == ST_CLEAR);
    assign load_from_file  = (state_q == ST_LOAD);
    assign Computing       = (state_q == ST_COMPUTE);
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign aborted         = aborted_q;
    assign state           = state_q;
    assign phase_count     = cnt_value_s;

`ifdef DOTP_SEQ_RUN_COUNT_EN
    logic [15:0] run_count_q;
    logic [15:0] run_count_d;

    // Saturating count of completed runs.
    always_comb begin
        run_count_d = run_count_q;
        if ((state_q == ST_DONE) && (run_count_q != 16'hFFFF)) begin
            run_count_d = run_count_q + 16'd1;
        end else begin
            run_count_d = run_count_q;
        end
    end

    // Run counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_count_q <= 16'd0;
        end else begin
            run_count_q <= run_count_d;
        end
    end

    assign run_count = run_count_q;
`endif

endmodule
